// File: rtl/battle_pkg.sv
// Shared definitions for battle-game objects: direction codes, mover FSM states
// and the keyboard-to-move decode used by every controllable object.
package battle_pkg;

  localparam int POS_INT_W = 11;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BLOCKED,
    ST_DEAD
  } mover_state_e;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } move_req_t;

  // Only a single pressed key is a request; chords and no-key leave dir alone.
  function automatic move_req_t decode_keys(input logic [3:0] keys);
    move_req_t req;
    req.valid = 1'b1;
    case (keys)
      4'b0001: req.dir = DIR_DOWN;
      4'b0010: req.dir = DIR_UP;
      4'b0100: req.dir = DIR_LEFT;
      4'b1000: req.dir = DIR_RIGHT;
      default: begin
        req.valid = 1'b0;
        req.dir   = DIR_UP;
      end
    endcase
    return req;
  endfunction

endpackage

// File: rtl/axis_step.sv
// One axis of fixed-point motion: adds a signed step to the position and
// clamps the result to the inclusive pixel bounds of the top-left corner.
module axis_step
  import battle_pkg::*;
#(
  parameter int  FRAC_BITS = 6,
  parameter int  MIN_PIX   = 0,
  parameter int  MAX_PIX   = 620,
  localparam int POS_W     = POS_INT_W + FRAC_BITS
) (
  input  logic        [POS_W-1:0] i_pos,
  input  logic signed [POS_W:0]   i_delta,
  output logic        [POS_W-1:0] o_pos
);

  localparam logic signed [POS_W:0] LO = (POS_W+1)'(MIN_PIX << FRAC_BITS);
  localparam logic signed [POS_W:0] HI = (POS_W+1)'(MAX_PIX << FRAC_BITS);

  // One extra bit keeps a step below zero negative so it clamps to MIN.
  logic signed [POS_W:0] w_sum;
  assign w_sum = $signed({1'b0, i_pos}) + i_delta;

  always_comb begin
    if (w_sum < LO)      o_pos = LO[POS_W-1:0];
    else if (w_sum > HI) o_pos = HI[POS_W-1:0];
    else                 o_pos = w_sum[POS_W-1:0];
  end

endmodule

// File: rtl/obj_mover.sv
// Keyboard-driven object mover: per-frame fixed-point motion with clamping,
// one-shot back-off on collision, and a timed death/respawn cycle.
module obj_mover
  import battle_pkg::*;
#(
  parameter int INIT_X         = 280,
  parameter int INIT_Y         = 185,
  parameter int INIT_DIR       = 1,
  parameter int SPEED          = 20,
  parameter int FRAC_BITS      = 6,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 620,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 460,
  parameter int RESPAWN_FRAMES = 90
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        collision,
  input  logic        hit,
  input  logic [3:0]  keys,
  input  logic        runEn,
  input  logic        resetPos,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  dir,
  output logic        alive,
  output logic        moving
);

  localparam int POS_W = POS_INT_W + FRAC_BITS;
  localparam int CNT_W = 16;
  localparam logic [POS_W-1:0]      INIT_X_FP   = POS_W'(INIT_X << FRAC_BITS);
  localparam logic [POS_W-1:0]      INIT_Y_FP   = POS_W'(INIT_Y << FRAC_BITS);
  localparam logic signed [POS_W:0] STEP        = (POS_W+1)'(SPEED);
  localparam dir_e                  INIT_DIR_E  = dir_e'(INIT_DIR[1:0]);
  localparam logic [CNT_W-1:0]      RESPAWN_CNT = CNT_W'(RESPAWN_FRAMES);

  mover_state_e          r_state, w_state_next;
  logic [POS_W-1:0]      r_pos_x, r_pos_y, w_x_next, w_y_next;
  logic signed [POS_W:0] r_last_dx, r_last_dy;
  logic signed [POS_W:0] w_req_dx, w_req_dy, w_dx, w_dy;
  dir_e                  r_dir;
  logic                  r_alive, r_moving;
  logic [CNT_W-1:0]      r_cnt;
  move_req_t             w_req;
  logic w_apply_move, w_backoff, w_load_init, w_kill, w_respawn, w_cnt_dec, w_moving_next;

  assign w_req = decode_keys(keys);

  always_comb begin
    w_req_dx = '0;
    w_req_dy = '0;
    case (w_req.dir)
      DIR_UP:    w_req_dy = -STEP;
      DIR_DOWN:  w_req_dy = STEP;
      DIR_LEFT:  w_req_dx = -STEP;
      DIR_RIGHT: w_req_dx = STEP;
      default:   ;
    endcase
  end

  // Back-off undoes the last recorded step through the same clamp path.
  assign w_dx = w_backoff ? -r_last_dx : w_req_dx;
  assign w_dy = w_backoff ? -r_last_dy : w_req_dy;

  axis_step #(.FRAC_BITS(FRAC_BITS), .MIN_PIX(X_MIN), .MAX_PIX(X_MAX)) u_axis_x (
    .i_pos  (r_pos_x),
    .i_delta(w_dx),
    .o_pos  (w_x_next)
  );

  axis_step #(.FRAC_BITS(FRAC_BITS), .MIN_PIX(Y_MIN), .MAX_PIX(Y_MAX)) u_axis_y (
    .i_pos  (r_pos_y),
    .i_delta(w_dy),
    .o_pos  (w_y_next)
  );

  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next  = r_state;
    w_apply_move  = 1'b0;
    w_backoff     = 1'b0;
    w_load_init   = 1'b0;
    w_kill        = 1'b0;
    w_respawn     = 1'b0;
    w_cnt_dec     = 1'b0;
    w_moving_next = 1'b0;
    if (r_state == ST_DEAD) begin
      if (startOfFrame) begin
        if (r_cnt <= CNT_W'(1)) begin
          w_respawn    = 1'b1;
          w_load_init  = 1'b1;
          w_state_next = runEn ? ST_RUN : ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
    end else if (hit) begin
      w_kill       = 1'b1;
      w_state_next = ST_DEAD;
    end else if (!runEn) begin
      w_state_next = ST_IDLE;
      w_load_init  = resetPos;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_RUN;
        ST_RUN: begin
          if (collision) begin
            w_backoff    = 1'b1;
            w_state_next = ST_BLOCKED;
          end else if (startOfFrame) begin
            w_apply_move  = w_req.valid;
            w_moving_next = w_req.valid;
          end else begin
            w_moving_next = r_moving;
          end
        end
        ST_BLOCKED: begin
          w_moving_next = r_moving;
          if (startOfFrame) begin
            // Still touching: only a move away from the obstacle releases the block.
            if (!collision || (w_req.valid && w_req.dir != r_dir)) begin
              w_state_next = ST_RUN;
              w_apply_move = w_req.valid;
            end
            w_moving_next = w_apply_move;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pos_x   <= INIT_X_FP;
      r_pos_y   <= INIT_Y_FP;
      r_dir     <= INIT_DIR_E;
      r_last_dx <= '0;
      r_last_dy <= '0;
      r_alive   <= 1'b1;
      r_moving  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_moving <= w_moving_next;
      if (w_load_init) begin
        r_pos_x   <= INIT_X_FP;
        r_pos_y   <= INIT_Y_FP;
        r_dir     <= INIT_DIR_E;
        r_last_dx <= '0;
        r_last_dy <= '0;
      end else if (w_apply_move) begin
        r_pos_x   <= w_x_next;
        r_pos_y   <= w_y_next;
        r_dir     <= w_req.dir;
        r_last_dx <= w_req_dx;
        r_last_dy <= w_req_dy;
      end else if (w_backoff) begin
        r_pos_x   <= w_x_next;
        r_pos_y   <= w_y_next;
        r_last_dx <= '0;
        r_last_dy <= '0;
      end
      if (w_kill) begin
        r_alive <= 1'b0;
        r_cnt   <= RESPAWN_CNT;
      end else if (w_respawn) begin
        r_alive <= 1'b1;
        r_cnt   <= '0;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign topLeftX = r_pos_x[POS_W-1:FRAC_BITS];
  assign topLeftY = r_pos_y[POS_W-1:FRAC_BITS];
  assign dir      = r_dir;
  assign alive    = r_alive;
  assign moving   = r_moving;

endmodule

// File: tb/tb_obj_mover.sv
// Scoreboard bench for obj_mover: two parameterisations share stimulus, a
// behavioural model predicts every cycle, and a monitor compares on negedge.
module tb_obj_mover;

  localparam int FRAC   = 64;
  localparam int SPEED  = 20;
  localparam int INIT_Y = 185;
  localparam int Y_MAXP = 460;
  localparam int M_IDLE = 0, M_RUN = 1, M_BLOCKED = 2, M_DEAD = 3;

  logic clk = 1'b0;
  logic resetN, startOfFrame, collision, hit, runEn, resetPos;
  logic [3:0] keys;
  logic [10:0] a_x, a_y, b_x, b_y;
  logic [1:0] a_dir, b_dir;
  logic a_alive, a_moving, b_alive, b_moving;

  always #5 clk = ~clk;

  obj_mover #(.RESPAWN_FRAMES(3)) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
    .hit(hit), .keys(keys), .runEn(runEn), .resetPos(resetPos),
    .topLeftX(a_x), .topLeftY(a_y), .dir(a_dir), .alive(a_alive), .moving(a_moving)
  );

  obj_mover #(.INIT_X(598), .X_MAX(600)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
    .hit(hit), .keys(keys), .runEn(runEn), .resetPos(resetPos),
    .topLeftX(b_x), .topLeftY(b_y), .dir(b_dir), .alive(b_alive), .moving(b_moving)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  dir;
    logic        alive;
    logic        moving;
  } obs_t;

  typedef struct {
    int px, py, dir, mode, cnt, ldx, ldy;
    bit alive, moving;
  } model_t;

  model_t ma, mb;
  obs_t q_a[$], q_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got x=%0d y=%0d dir=%0d alive=%0b moving=%0b expected x=%0d y=%0d dir=%0d alive=%0b moving=%0b",
               name, $time, act.x, act.y, act.dir, act.alive, act.moving,
               exp.x, exp.y, exp.dir, exp.alive, exp.moving);
    end
  endtask

  function automatic int clampv(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void spawn(inout model_t m, input int init_x);
    m.px = init_x * FRAC;
    m.py = INIT_Y * FRAC;
    m.dir = 1;
    m.ldx = 0;
    m.ldy = 0;
  endfunction

  function automatic void shift(inout model_t m, input int dx, input int dy, input int x_max);
    m.px = clampv(m.px + dx, 0, x_max * FRAC);
    m.py = clampv(m.py + dy, 0, Y_MAXP * FRAC);
  endfunction

  // One clock of behaviour, using the inputs as they stand at this edge.
  function automatic void step(inout model_t m, input int init_x, input int x_max, input int respawn);
    int rdx, rdy, rdir;
    bit req, allowed;
    req = 1'b1; rdx = 0; rdy = 0; rdir = 0;
    case (keys)
      4'b0001: begin rdy = SPEED;  rdir = 2; end
      4'b0010: begin rdy = -SPEED; rdir = 0; end
      4'b0100: begin rdx = -SPEED; rdir = 3; end
      4'b1000: begin rdx = SPEED;  rdir = 1; end
      default: req = 1'b0;
    endcase
    if (!resetN) begin
      spawn(m, init_x);
      m.mode = M_IDLE; m.alive = 1; m.moving = 0; m.cnt = 0;
      return;
    end
    if (m.mode == M_DEAD) begin
      m.moving = 0;
      if (startOfFrame) begin
        if (m.cnt <= 1) begin
          spawn(m, init_x);
          m.alive = 1; m.cnt = 0;
          m.mode = runEn ? M_RUN : M_IDLE;
        end else m.cnt--;
      end
      return;
    end
    if (hit) begin
      m.mode = M_DEAD; m.alive = 0; m.cnt = respawn; m.moving = 0;
      return;
    end
    if (!runEn) begin
      m.mode = M_IDLE; m.moving = 0;
      if (resetPos) spawn(m, init_x);
      return;
    end
    if (m.mode == M_IDLE) begin
      m.mode = M_RUN; m.moving = 0;
      return;
    end
    if (m.mode == M_RUN && collision) begin
      shift(m, -m.ldx, -m.ldy, x_max);
      m.ldx = 0; m.ldy = 0; m.mode = M_BLOCKED; m.moving = 0;
      return;
    end
    if (!startOfFrame) return;
    allowed = req && !(m.mode == M_BLOCKED && collision && rdir == m.dir);
    if (m.mode == M_BLOCKED && collision && !allowed) begin
      m.moving = 0;
      return;
    end
    m.mode = M_RUN;
    m.moving = allowed;
    if (allowed) begin
      shift(m, rdx, rdy, x_max);
      m.dir = rdir; m.ldx = rdx; m.ldy = rdy;
    end
  endfunction

  function automatic obs_t to_obs(input model_t m);
    obs_t o;
    o.x = 11'(m.px / FRAC);
    o.y = 11'(m.py / FRAC);
    o.dir = 2'(m.dir);
    o.alive = m.alive;
    o.moving = m.moving;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    step(ma, 280, 620, 3);
    step(mb, 598, 600, 90);
    q_a.push_back(to_obs(ma));
    q_b.push_back(to_obs(mb));
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check_obs("sb_a", {a_x, a_y, a_dir, a_alive, a_moving}, e);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check_obs("sb_b", {b_x, b_y, b_dir, b_alive, b_moving}, e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    resetN = 1'b0; startOfFrame = 1'b0; collision = 1'b0; hit = 1'b0;
    runEn = 1'b0; resetPos = 1'b0; keys = 4'b0000;
    repeat (3) tick();
    resetN = 1'b1;
    tick();
    check("rst_x", a_x, 280);
    check("rst_y", a_y, 185);
    check("rst_dir", a_dir, 1);
    check("rst_alive", a_alive, 1);
    check("rst_moving", a_moving, 0);
    check("rst_b_x", b_x, 598);

    // Move right for 64 frames; B saturates at its right bound.
    runEn = 1'b1; keys = 4'b1000;
    tick();
    for (int f = 0; f < 64; f++) begin
      frames(1);
      check("b_x_bound", b_x > 11'd600, 0);
      if (f == 19) check("b_x_sat", b_x, 600);
    end
    check("run_x", a_x, 300);
    check("run_y", a_y, 185);
    check("run_dir", a_dir, 1);
    check("run_alive", a_alive, 1);
    check("run_moving", a_moving, 1);

    // Hit, dead for three frames, respawn at the spawn point.
    hit = 1'b1; tick(); hit = 1'b0;
    check("dead_alive", a_alive, 0);
    frames(2);
    check("dead_alive2", a_alive, 0);
    check("dead_x_frozen", a_x, 300);
    frames(1);
    check("respawn_alive", a_alive, 1);
    check("respawn_x", a_x, 280);
    check("respawn_y", a_y, 185);
    check("respawn_dir", a_dir, 1);

    // Up four frames, collide, hold against the obstacle, then leave sideways.
    keys = 4'b0010;
    frames(4);
    check("up_y", a_y, 183);
    collision = 1'b1; tick();
    check("backoff_y", a_y, 184);
    frames(3);
    check("blocked_y", a_y, 184);
    collision = 1'b0; keys = 4'b0100;
    frames(4);
    check("left_x", a_x, 278);
    check("left_y", a_y, 184);
    check("left_moving", a_moving, 1);

    // Hit and collision together: death wins, no back-off.
    keys = 4'b0000; hit = 1'b1; collision = 1'b1;
    tick();
    hit = 1'b0; collision = 1'b0;
    check("hitcol_x", a_x, 278);
    check("hitcol_alive", a_alive, 0);
    keys = 4'b1100;
    frames(1);
    check("chord_x", a_x, 278);
    check("chord_dir", a_dir, 3);
    frames(2);
    check("respawn2_x", a_x, 280);

    // resetPos only acts while runEn is low.
    keys = 4'b0001;
    frames(5);
    check("down_y", a_y, 186);
    check("down_dir", a_dir, 2);
    runEn = 1'b0; tick();
    resetPos = 1'b1; tick(); resetPos = 1'b0;
    check("rpos_x", a_x, 280);
    check("rpos_y", a_y, 185);
    check("rpos_dir", a_dir, 1);
    runEn = 1'b1; tick();
    frames(4);
    keys = 4'b0000;
    resetPos = 1'b1; tick(); tick(); resetPos = 1'b0;
    check("rpos_ign_y", a_y, 186);
    check("rpos_ign_dir", a_dir, 2);

    // Reset aborts BLOCKED and DEAD.
    collision = 1'b1; tick();
    check("blk_y", a_y, 185);
    resetN = 1'b0; tick();
    check("rst_blk_dir", a_dir, 1);
    check("rst_blk_x", a_x, 280);
    resetN = 1'b1; collision = 1'b0; tick();
    hit = 1'b1; tick(); hit = 1'b0;
    check("pre_rst_dead", a_alive, 0);
    resetN = 1'b0; tick();
    check("rst_dead_alive", a_alive, 1);
    resetN = 1'b1; tick();

    // Randomised traffic, checked cycle by cycle through the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      startOfFrame = ($urandom_range(0, 3) == 0);
      collision    = ($urandom_range(0, 7) == 0);
      hit          = ($urandom_range(0, 299) == 0);
      runEn        = ($urandom_range(0, 15) != 0);
      resetPos     = ($urandom_range(0, 7) == 0);
      resetN       = ($urandom_range(0, 255) != 0);
      k = $urandom_range(0, 3);
      keys = (k < 3) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      tick();
    end
    resetN = 1'b1; startOfFrame = 1'b0; collision = 1'b0; hit = 1'b0;

    repeat (3) @(negedge clk);
    check("drain", q_a.size() + q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
